// File: rtl/tpsram_responder.sv
// QSPI/QPI pseudo-SRAM responder: SPI 0x35 enters QPI mode, QPI 0xEB reads, 0x02 writes, 0xF5 exits.
// Optional macro TPSRAM_RESP_PAGEWRAP_EN keeps bursts inside a 1024-byte page.
module tpsram_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps_cs,
  input  logic [3:0]  ps_din,
  output logic [3:0]  ps_dout,
  output logic [3:0]  ps_oe,
  output logic [23:0] mem_addr,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  output logic        qpi_mode
);

  typedef enum logic [2:0] {
    IDLE, SCMD, QCMD, QADDR, RWAIT, RDATA, WDATA, IGNORE
  } state_t;

  state_t      state;
  logic [3:0]  k;
  logic [7:0]  cmd;
  logic [23:0] addr;
  logic [3:0]  hi_nib;
  logic [3:0]  lo_nib;
  logic        armed;

  function automatic logic [23:0] next_addr(input logic [23:0] a);
`ifdef TPSRAM_RESP_PAGEWRAP_EN
    next_addr = {a[23:10], a[9:0] + 10'd1};
`else
    next_addr = a + 24'd1;
`endif
  endfunction

  // k only needs to reach 13; in the data phases its LSB tracks the high/low nibble.
  // armed stays low after reset until CS has been seen high once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      k         <= 4'd0;
      cmd       <= 8'h00;
      addr      <= 24'h000000;
      hi_nib    <= 4'h0;
      lo_nib    <= 4'h0;
      armed     <= 1'b0;
      ps_dout   <= 4'h0;
      ps_oe     <= 4'h0;
      mem_addr  <= 24'h000000;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'h00;
      qpi_mode  <= 1'b0;
    end else begin
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      if (ps_cs) begin
        state <= IDLE;
        k     <= 4'd0;
        ps_oe <= 4'h0;
        armed <= 1'b1;
      end else begin
        k <= k + 4'd1;
        case (state)
          IDLE: begin
            if (!armed) begin
              state <= IGNORE;
            end else if (qpi_mode) begin
              cmd   <= {ps_din, 4'h0};
              state <= QCMD;
            end else begin
              cmd   <= {7'h00, ps_din[0]};
              state <= SCMD;
            end
          end
          SCMD: begin
            cmd <= {cmd[6:0], ps_din[0]};
            if (k == 4'd7) begin
              if ({cmd[6:0], ps_din[0]} == 8'h35) qpi_mode <= 1'b1;
              state <= IGNORE;
            end
          end
          QCMD: begin
            cmd <= {cmd[7:4], ps_din};
            case ({cmd[7:4], ps_din})
              8'hEB, 8'h02: state <= QADDR;
              8'hF5: begin
                qpi_mode <= 1'b0;
                state    <= IGNORE;
              end
              default: state <= IGNORE;
            endcase
          end
          QADDR: begin
            addr <= {addr[19:0], ps_din};
            if (k == 4'd7) state <= (cmd == 8'hEB) ? RWAIT : WDATA;
          end
          RWAIT: begin
            if (k == 4'd12) begin
              mem_re   <= 1'b1;
              mem_addr <= addr;
              addr     <= next_addr(addr);
            end else if (k == 4'd13) begin
              state <= RDATA;
            end
          end
          // The next byte is fetched while the current one is shifted out.
          RDATA: begin
            if (!k[0]) begin
              ps_oe    <= 4'hF;
              ps_dout  <= mem_rdata[7:4];
              lo_nib   <= mem_rdata[3:0];
              mem_re   <= 1'b1;
              mem_addr <= addr;
              addr     <= next_addr(addr);
            end else begin
              ps_dout <= lo_nib;
            end
          end
          WDATA: begin
            if (!k[0]) begin
              hi_nib <= ps_din;
            end else begin
              mem_we    <= 1'b1;
              mem_wdata <= {hi_nib, ps_din};
              mem_addr  <= addr;
              addr      <= next_addr(addr);
            end
          end
          IGNORE: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tpsram_responder.sv
// Scoreboard bench for tpsram_responder: stimulus pushes expected strobes/nibbles, a monitor pops and compares.
module tb_tpsram_responder;

  logic        clk;
  logic        reset;
  logic        ps_cs;
  logic [3:0]  ps_din;
  logic [3:0]  ps_dout;
  logic [3:0]  ps_oe;
  logic [23:0] mem_addr;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        qpi_mode;

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  data;
    int          edge_k;
  } exp_t;

  exp_t wr_q[$];
  exp_t re_q[$];
  exp_t nib_q[$];

  int vectors = 0;
  int miscompares = 0;
  int tb_k;

  logic [7:0] mem [0:4095];

  tpsram_responder dut (
    .clk       (clk),
    .reset     (reset),
    .ps_cs     (ps_cs),
    .ps_din    (ps_din),
    .ps_dout   (ps_dout),
    .ps_oe     (ps_oe),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .qpi_mode  (qpi_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[11:0]];
  end

  // Edge index k: after edge k is sampled, tb_k reads k+1.
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_k <= 0;
    else if (ps_cs) tb_k <= 0;
    else tb_k <= tb_k + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic report_unexpected(input string name, input logic [31:0] actual);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: unexpected output 0x%0h with nothing expected", name, actual);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (mem_re) begin
        if (re_q.size() == 0) report_unexpected("mem_re", {8'h00, mem_addr});
        else begin
          e = re_q.pop_front();
          checkOutput("mem_re addr", {8'h00, mem_addr}, {8'h00, e.addr});
          checkOutput("mem_re edge", tb_k, e.edge_k + 1);
        end
      end
      if (mem_we) begin
        if (wr_q.size() == 0) report_unexpected("mem_we", {mem_wdata, mem_addr});
        else begin
          e = wr_q.pop_front();
          checkOutput("mem_we addr", {8'h00, mem_addr}, {8'h00, e.addr});
          checkOutput("mem_we data", {24'h0, mem_wdata}, {24'h0, e.data});
          checkOutput("mem_we edge", tb_k, e.edge_k + 1);
        end
      end
      if (ps_oe != 4'h0) begin
        if (nib_q.size() == 0) report_unexpected("ps_oe", {28'h0, ps_oe});
        else begin
          e = nib_q.pop_front();
          checkOutput("ps_oe", {28'h0, ps_oe}, 32'hF);
          checkOutput("ps_dout", {28'h0, ps_dout}, {24'h0, e.data});
          checkOutput("ps_dout edge", tb_k, e.edge_k + 1);
        end
      end
    end
  end

  // One bus cycle with CS low; called and returns at a negedge.
  task automatic applyStimulus(input logic [3:0] nib);
    ps_cs  = 1'b0;
    ps_din = nib;
    @(negedge clk);
  endtask

  task automatic end_cs();
    ps_cs  = 1'b1;
    ps_din = 4'h0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) applyStimulus({3'b000, b[i]});
  endtask

  task automatic send_qpi_hdr(input logic [7:0] cmd, input logic [23:0] a);
    applyStimulus(cmd[7:4]);
    applyStimulus(cmd[3:0]);
    for (int i = 5; i >= 0; i--) applyStimulus(a[i*4 +: 4]);
  endtask

  task automatic push_wr(input logic [23:0] a, input logic [7:0] d, input int ek);
    exp_t e;
    e.addr = a; e.data = d; e.edge_k = ek;
    wr_q.push_back(e);
  endtask

  task automatic push_re(input logic [23:0] a, input int ek);
    exp_t e;
    e.addr = a; e.data = 8'h00; e.edge_k = ek;
    re_q.push_back(e);
  endtask

  task automatic push_nib(input logic [3:0] n, input int ek);
    exp_t e;
    e.addr = 24'h0; e.data = {4'h0, n}; e.edge_k = ek;
    nib_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] spi35;
    logic [7:0] wbytes [4];
    logic [23:0] wrap_addr;
    spi35 = 8'h35;
    wbytes[0] = 8'h11; wbytes[1] = 8'h22; wbytes[2] = 8'h33; wbytes[3] = 8'h44;
`ifdef TPSRAM_RESP_PAGEWRAP_EN
    wrap_addr = 24'h000000;
`else
    wrap_addr = 24'h000400;
`endif

    reset  = 1'b0;
    ps_cs  = 1'b1;
    ps_din = 4'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset qpi_mode", {31'h0, qpi_mode}, 0);
    checkOutput("reset ps_oe", {28'h0, ps_oe}, 0);
    checkOutput("reset ps_dout", {28'h0, ps_dout}, 0);
    checkOutput("reset mem_re", {31'h0, mem_re}, 0);
    checkOutput("reset mem_we", {31'h0, mem_we}, 0);
    checkOutput("reset mem_addr", {8'h0, mem_addr}, 0);
    checkOutput("reset mem_wdata", {24'h0, mem_wdata}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] SPI 0x35 enters QPI");
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) checkOutput("qpi_mode before k=7", {31'h0, qpi_mode}, 0);
      applyStimulus({3'b000, spi35[i]});
    end
    checkOutput("qpi_mode after k=7", {31'h0, qpi_mode}, 1);
    end_cs();

    $display("[TB] QPI write 0x11223344 @0x100");
    for (int m = 0; m < 4; m++) push_wr(24'h000100 + m, wbytes[m], 9 + 2*m);
    send_qpi_hdr(8'h02, 24'h000100);
    for (int m = 0; m < 4; m++) begin
      applyStimulus(wbytes[m][7:4]);
      applyStimulus(wbytes[m][3:0]);
    end
    end_cs();

    $display("[TB] QPI read @0x100");
    for (int m = 0; m < 5; m++) push_re(24'h000100 + m, 12 + 2*m);
    for (int m = 0; m < 4; m++) begin
      push_nib(wbytes[m][7:4], 14 + 2*m);
      push_nib(wbytes[m][3:0], 15 + 2*m);
    end
    send_qpi_hdr(8'hEB, 24'h000100);
    for (int i = 8; i <= 13; i++) applyStimulus(4'h0);
    checkOutput("ps_oe after edge 13", {28'h0, ps_oe}, 0);
    for (int i = 14; i <= 21; i++) applyStimulus(4'h0);
    ps_cs = 1'b1;
    @(negedge clk);
    checkOutput("ps_oe after read CS high", {28'h0, ps_oe}, 0);
    @(negedge clk);

    $display("[TB] write across 0x3FF boundary");
    push_wr(24'h0003FF, 8'hAA, 9);
    push_wr(wrap_addr, 8'hBB, 11);
    send_qpi_hdr(8'h02, 24'h0003FF);
    applyStimulus(4'hA); applyStimulus(4'hA);
    applyStimulus(4'hB); applyStimulus(4'hB);
    end_cs();

    $display("[TB] write aborted after 3 nibbles");
    push_wr(24'h000200, 8'hAB, 9);
    send_qpi_hdr(8'h02, 24'h000200);
    applyStimulus(4'hA); applyStimulus(4'hB); applyStimulus(4'hC);
    ps_cs = 1'b1;
    @(negedge clk);
    checkOutput("ps_oe after abort", {28'h0, ps_oe}, 0);
    repeat (3) @(negedge clk);

    $display("[TB] QPI 0xF5 exits QPI");
    applyStimulus(4'hF);
    checkOutput("qpi_mode after F5 k=0", {31'h0, qpi_mode}, 1);
    applyStimulus(4'h5);
    checkOutput("qpi_mode after F5 k=1", {31'h0, qpi_mode}, 0);
    end_cs();

    $display("[TB] QPI-format 0xEB in SPI mode is ignored");
    send_qpi_hdr(8'hEB, 24'h000100);
    for (int i = 8; i <= 21; i++) applyStimulus(4'h0);
    checkOutput("ps_oe ignored read", {28'h0, ps_oe}, 0);
    checkOutput("qpi_mode ignored read", {31'h0, qpi_mode}, 0);
    end_cs();

    $display("[TB] reset mid-transaction");
    send_spi_byte(8'h35);
    end_cs();
    checkOutput("qpi_mode re-entered", {31'h0, qpi_mode}, 1);
    send_qpi_hdr(8'h02, 24'h000300);
    applyStimulus(4'h5);
    reset = 1'b0;
    #1;
    checkOutput("async reset qpi_mode", {31'h0, qpi_mode}, 0);
    checkOutput("async reset mem_addr", {8'h0, mem_addr}, 0);
    @(negedge clk);
    reset = 1'b1;
    send_spi_byte(8'h35);
    checkOutput("qpi_mode ignored until CS high", {31'h0, qpi_mode}, 0);
    end_cs();
    send_spi_byte(8'h35);
    end_cs();
    checkOutput("qpi_mode after CS cycle", {31'h0, qpi_mode}, 1);

    for (int i = 0; i < 20 && (wr_q.size() + re_q.size() + nib_q.size()) != 0; i++) @(negedge clk);
    checkOutput("scoreboard drained", wr_q.size() + re_q.size() + nib_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
